// File: rtl/riscv_pkg.sv
// Shared types for the response/writeback steering logic.
package riscv_pkg;
   localparam int NUM_DEST = 4;
   typedef logic [1:0] dest_sel_t;
endpackage

// File: rtl/skid_buffer.sv
// Generic two-entry valid/ready register: a head slot that drives the consumer and
// a skid slot that catches the one word in flight when the consumer stalls.
module skid_buffer #(
   parameter int PW = 34
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_data,
   output logic          busy
);
   logic          head_valid_q, head_valid_d;
   logic          skid_valid_q, skid_valid_d;
   logic [PW-1:0] head_data_q, head_data_d;
   logic [PW-1:0] skid_data_q, skid_data_d;
   logic          acc, drn;

   // in_ready comes straight from a flop, so out_ready never reaches the producer
   assign in_ready  = ~skid_valid_q;
   assign acc       = in_valid & ~skid_valid_q;
   assign drn       = head_valid_q & out_ready;
   assign out_valid = head_valid_q;
   assign out_data  = head_data_q;
   assign busy      = head_valid_q | skid_valid_q;

   always_comb begin
      head_valid_d = head_valid_q;
      skid_valid_d = skid_valid_q;
      head_data_d  = head_data_q;
      skid_data_d  = skid_data_q;
      if (!head_valid_q) begin
         if (acc) begin
            head_valid_d = 1'b1;
            head_data_d  = in_data;
         end
      end else if (!skid_valid_q) begin
         if (acc && drn) begin
            head_data_d = in_data;
         end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end else if (drn) begin
            head_valid_d = 1'b0;
         end
      end else if (drn) begin
         // skid full means no accept this cycle; promote the parked word
         head_data_d  = skid_data_q;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         head_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         head_data_q  <= head_data_d;
         skid_data_q  <= skid_data_d;
      end
   end
endmodule

// File: rtl/demux1to4_pipe.sv
// Registered 1-to-4 demux: one valid/ready stream steered per word to one of four
// consumers, strictly in order (a stalled head blocks words for other ports).
module demux1to4_pipe
   import riscv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_data,
   input  dest_sel_t           in_sel,
   output logic [NUM_DEST-1:0] out_valid,
   input  logic [NUM_DEST-1:0] out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic                busy
);
   localparam int SW = $bits(dest_sel_t);
   localparam int PW = SW + WIDTH;

   logic [PW-1:0] head_payload;
   logic          head_valid;
   logic          head_ready;
   dest_sel_t     head_sel;

   skid_buffer #(.PW(PW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_sel, in_data}),
      .out_valid (head_valid),
      .out_ready (head_ready),
      .out_data  (head_payload),
      .busy      (busy)
   );

   assign head_sel   = head_payload[PW-1 -: SW];
   assign out_data   = head_payload[WIDTH-1:0];
   // only the addressed consumer's ready can retire the head word
   assign head_ready = out_ready[head_sel];

   always_comb begin
      out_valid = '0;
      if (head_valid) out_valid[head_sel] = 1'b1;
   end
endmodule
